// File: rtl/corelet_ctrl.sv
// Layer sequencer for the corelet: per kernel position runs weight load, activation load,
// execute and OFIFO drain. Optional counters enabled by defining CORELET_CTRL_PERF_EN.
module corelet_ctrl #(
    parameter int row   = 8,
    parameter int col   = 8,
    parameter int NIJ   = 36,
    parameter int KIJ   = 9,
    parameter int WBASE = 0,
    parameter int ABASE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        base_zero,
    output logic [3:0]  kij_idx,
    output logic        busy,
    output logic        done
`ifdef CORELET_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int CW = 16;
    localparam logic [33:0]   IDLE_INST  = 34'h1_800C_0000;
    localparam logic [CW-1:0] C_COL      = CW'(col);
    localparam logic [CW-1:0] C_WKL_LAST = CW'(row + col - 1);
    localparam logic [CW-1:0] C_NIJ      = CW'(NIJ);
    localparam logic [CW-1:0] C_NIJ_LAST = CW'(NIJ - 1);
    localparam logic [CW-1:0] C_EXE_LAST = CW'(NIJ + row + col - 1);
    localparam logic [3:0]    C_KLAST    = 4'(KIJ - 1);

    typedef enum logic [2:0] {S_IDLE, S_WLD, S_WKL, S_ALD, S_EXE, S_DRN, S_FIN} state_t;
    typedef enum logic [1:0] {P_R, P_W, P_STALL} phase_t;

    state_t        r_state, w_state;
    phase_t        r_phase, w_phase;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_kij, w_kij;
    logic [33:0]   r_inst, w_inst;
    logic          r_base_zero, r_busy, r_done;

    // Sequencing state describes the cycle currently on the outputs; the decode below
    // works on the next state so every output leaves a flop.
    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_cnt   = r_cnt;
        w_kij   = r_kij;
        case (r_state)
            S_IDLE: if (start) begin
                w_state = S_WLD;
                w_cnt   = '0;
                w_kij   = '0;
            end
            S_WLD: if (r_cnt == C_COL) begin
                w_state = S_WKL;
                w_cnt   = '0;
            end else w_cnt = r_cnt + CW'(1);
            S_WKL: if (r_cnt == C_WKL_LAST) begin
                w_state = S_ALD;
                w_cnt   = '0;
            end else w_cnt = r_cnt + CW'(1);
            S_ALD: if (r_cnt == C_NIJ) begin
                w_state = S_EXE;
                w_cnt   = '0;
            end else w_cnt = r_cnt + CW'(1);
            S_EXE: if (r_cnt == C_EXE_LAST) begin
                w_state = S_DRN;
                w_cnt   = '0;
                w_phase = ofifo_valid ? P_R : P_STALL;
            end else w_cnt = r_cnt + CW'(1);
            S_DRN: begin
                case (r_phase)
                    P_R: w_phase = P_W;
                    P_W: begin
                        if (r_cnt == C_NIJ_LAST) begin
                            w_cnt = '0;
                            if (r_kij == C_KLAST) w_state = S_FIN;
                            else begin
                                w_state = S_WLD;
                                w_kij   = r_kij + 4'd1;
                            end
                        end else begin
                            w_cnt   = r_cnt + CW'(1);
                            w_phase = ofifo_valid ? P_R : P_STALL;
                        end
                    end
                    default: if (ofifo_valid) w_phase = P_R;
                endcase
            end
            S_FIN: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_kij   = '0;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_inst = IDLE_INST;
        case (w_state)
            S_WLD: begin
                if (w_cnt < C_COL) begin
                    w_inst[19]   = 1'b0;
                    w_inst[17:7] = 11'(WBASE) + 11'(w_kij) * 11'(col) + w_cnt[10:0];
                end
                w_inst[2] = (w_cnt != '0);
            end
            S_WKL: begin
                w_inst[0] = 1'b1;
                w_inst[3] = (w_cnt < C_COL);
            end
            S_ALD: begin
                if (w_cnt < C_NIJ) begin
                    w_inst[19]   = 1'b0;
                    w_inst[17:7] = 11'(ABASE) + w_cnt[10:0];
                end
                w_inst[2] = (w_cnt != '0);
            end
            S_EXE: begin
                w_inst[1] = (w_cnt < C_NIJ);
                w_inst[3] = (w_cnt < C_NIJ);
            end
            S_DRN: begin
                w_inst[33] = (w_kij != C_KLAST);
                if (w_phase != P_STALL) begin
                    w_inst[32]    = 1'b0;
                    w_inst[31]    = (w_phase == P_R);
                    w_inst[30:20] = w_cnt[10:0];
                    w_inst[6]     = (w_phase == P_R);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_phase     <= P_R;
            r_cnt       <= '0;
            r_kij       <= '0;
            r_inst      <= IDLE_INST;
            r_base_zero <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_phase     <= w_phase;
            r_cnt       <= w_cnt;
            r_kij       <= w_kij;
            r_inst      <= w_inst;
            r_base_zero <= (w_state == S_DRN) && (w_kij == 4'd0);
            r_busy      <= (w_state != S_IDLE) && (w_state != S_FIN);
            r_done      <= (w_state == S_FIN);
        end
    end

    assign inst      = r_inst;
    assign base_zero = r_base_zero;
    assign kij_idx   = r_kij;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef CORELET_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt, r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset || (r_state == S_IDLE && start)) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_busy) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (r_state == S_DRN && r_phase == P_STALL) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: builds the expected per-cycle output trace of a layer from the
// pass structure and compares the DUT against it every cycle.
module tb_corelet_ctrl;

    localparam int ROW = 8, COL = 8, NIJ = 36, KIJ = 9, WBASE = 0, ABASE = 128;
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    typedef struct packed {
        logic [33:0] inst;
        logic        bz;
        logic [3:0]  kij;
        logic        busy;
        logic        done;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [33:0] inst;
    logic        base_zero, busy, done;
    logic [3:0]  kij_idx;
`ifdef CORELET_CTRL_PERF_EN
    logic [31:0] cycle_cnt, stall_cnt;
    logic [31:0] cc_done, sc_done;
`endif

    corelet_ctrl #(.row(ROW), .col(COL), .NIJ(NIJ), .KIJ(KIJ), .WBASE(WBASE), .ABASE(ABASE)) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .base_zero(base_zero), .kij_idx(kij_idx), .busy(busy), .done(done)
`ifdef CORELET_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    vec_t exp_a [0:2047];
    int   exp_w = 0;
    int   exp_n = 0;
    int   mon_idx = 0;
    int   done_cyc = -1;
    bit   mon_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t e;

    function automatic logic [33:0] mk(input logic acc, input logic pcen, input logic pwen, input int pa,
                                       input logic xcen, input int xa, input logic ofrd, input logic l0rd,
                                       input logic l0wr, input logic ex, input logic ld);
        logic [10:0] pa11, xa11;
        pa11 = 11'(pa);
        xa11 = 11'(xa);
        return {acc, pcen, pwen, pa11, xcen, 1'b1, xa11, ofrd, 2'b00, l0rd, l0wr, ex, ld};
    endfunction

    task automatic push(input logic [33:0] w, input logic bz, input int k, input logic b, input logic d);
        exp_a[exp_w] = {w, bz, 4'(k), b, d};
        exp_w++;
    endtask

    // Expected trace for one layer; sn stall cycles precede the read of pixel spx in pass sp.
    task automatic build(input int sp, input int spx, input int sn);
        logic acc, bz;
        exp_n = 0;
        exp_w = 0;
        for (int k = 0; k < KIJ; k++) begin
            acc = (k != KIJ - 1);
            bz  = (k == 0);
            for (int i = 0; i <= COL; i++)
                push(mk(0, 1, 1, 0, (i >= COL), (i < COL) ? WBASE + k * COL + i : 0, 0, 0, (i >= 1), 0, 0), 0, k, 1, 0);
            for (int i = 0; i < ROW + COL; i++)
                push(mk(0, 1, 1, 0, 1, 0, 0, (i < COL), 0, 0, 1), 0, k, 1, 0);
            for (int j = 0; j <= NIJ; j++)
                push(mk(0, 1, 1, 0, (j >= NIJ), (j < NIJ) ? ABASE + j : 0, 0, 0, (j >= 1), 0, 0), 0, k, 1, 0);
            for (int i = 0; i < NIJ + ROW + COL; i++)
                push(mk(0, 1, 1, 0, 1, 0, 0, (i < NIJ), 0, (i < NIJ), 0), 0, k, 1, 0);
            for (int p = 0; p < NIJ; p++) begin
                if (k == sp && p == spx)
                    for (int s = 0; s < sn; s++) push(mk(acc, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0), bz, k, 1, 0);
                push(mk(acc, 0, 1, p, 1, 0, 1, 0, 0, 0, 0), bz, k, 1, 0);
                push(mk(acc, 0, 0, p, 1, 0, 0, 0, 0, 0, 0), bz, k, 1, 0);
            end
        end
        push(IDLE_INST, 0, KIJ - 1, 0, 1);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            e = (mon_idx < exp_n) ? exp_a[mon_idx] : vec_t'({IDLE_INST, 1'b0, 4'd0, 1'b0, 1'b0});
            vectors++;
            if ({inst, base_zero, kij_idx, busy, done} !== e) begin
                miscompares++;
                $display("FAIL cycle %0d: inst=%h bz=%b kij=%0d busy=%b done=%b expected inst=%h bz=%b kij=%0d busy=%b done=%b",
                         mon_idx, inst, base_zero, kij_idx, busy, done, e.inst, e.bz, e.kij, e.busy, e.done);
            end
            if (done === 1'b1) begin
                done_cyc = mon_idx;
`ifdef CORELET_CTRL_PERF_EN
                cc_done = cycle_cnt;
                sc_done = stall_cnt;
`endif
            end
            mon_idx++;
        end
    end

    task automatic do_start();
        @(posedge clk); #2;
        exp_n = 0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        mon_idx  = 0;
        done_cyc = -1;
        exp_n    = exp_w;
    endtask

    // ofifo_valid is low for stall_len consecutive sampling edges starting at the edge that
    // begins cycle stall_at; stop_at >= 0 returns early with the DUT showing that cycle.
    task automatic run_layer(input int stall_at, input int stall_len, input int busy_start_at, input int stop_at);
        bit finished = 1'b0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(posedge clk); #2;
            ofifo_valid = (stall_len > 0 && mon_idx >= stall_at - 1 && mon_idx < stall_at - 1 + stall_len) ? 1'b0 : 1'b1;
            start = (mon_idx == busy_start_at);
            if (done_cyc >= 0) finished = 1'b1;
            if (stop_at >= 0 && mon_idx == stop_at) finished = 1'b1;
        end
        ofifo_valid = 1'b1;
        start = 1'b0;
        if (stop_at < 0) chk("layer_done_seen", (done_cyc >= 0), 1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_inst", inst, IDLE_INST);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_bz", base_zero, 0);
        chk("reset_kij", kij_idx, 0);
        reset = 1'b1;
        mon_en = 1'b1;

        build(-1, 0, 0);
        chk("model_len", exp_w, 1675);
        chk("model_wld0", exp_a[0].inst, 34'h1_8004_0000);
        chk("model_wld1", exp_a[1].inst, 34'h1_8004_0084);
        chk("model_wkl0", exp_a[9].inst, 34'h1_800C_0009);
        chk("model_ald0", exp_a[25].inst, 34'h1_8004_4000);
        chk("model_drn_r0", {exp_a[114].inst, exp_a[114].bz}, {34'h2_800C_0040, 1'b1});
        chk("model_pass1_w", exp_a[186].inst, 34'h1_8004_0400);
        chk("model_last_w35", {exp_a[1673].inst, exp_a[1673].bz}, {34'h0_023C_0000, 1'b0});
        chk("model_fin", {exp_a[1674].inst, exp_a[1674].busy, exp_a[1674].done}, {IDLE_INST, 1'b0, 1'b1});

        do_start();
        run_layer(0, 0, 300, -1);
        chk("done_nominal", done_cyc, 1674);
        repeat (5) @(posedge clk);

        build(3, 5, 10);
        chk("model_stall_len", exp_w, 1685);
        do_start();
        run_layer(682, 10, -1, -1);
        chk("done_stalled", done_cyc, 1684);
`ifdef CORELET_CTRL_PERF_EN
        chk("perf_cycle_cnt", cc_done, 1684);
        chk("perf_stall_cnt", sc_done, 10);
`endif
        repeat (5) @(posedge clk);

        build(-1, 0, 0);
        do_start();
        run_layer(0, 0, -1, 4 * 186 + 70);
        exp_n = mon_idx + 1;
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);

        build(-1, 0, 0);
        do_start();
        run_layer(0, 0, -1, -1);
        chk("done_after_reset", done_cyc, 1674);
        repeat (3) @(posedge clk);

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
